// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command sender: inhibit, start, 8 data + odd parity + stop, ack check.
// done/error pulse one cycle after the final state decision; send_valid is dropped while busy.
module ps2_host_tx #(
   parameter int CLK_INHIBIT_CYCLES = 5000,
   parameter int START_HOLD_CYCLES  = 100,
   parameter int TIMEOUT_CYCLES     = 750000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] send_data,
   input  logic       send_valid,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int PHASE_MAX = (CLK_INHIBIT_CYCLES > START_HOLD_CYCLES) ?
                              CLK_INHIBIT_CYCLES : START_HOLD_CYCLES;
   localparam int CW = $clog2(PHASE_MAX + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      START,
      SEND,
      ACK,
      WAIT_IDLE
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      clk_sync_q, dat_sync_q;
   logic            clk_prev_q;
   logic [7:0]      data_q, data_d;
   logic            parity_q, parity_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]   phase_cnt_q, phase_cnt_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            dat_oe_q, dat_oe_d;
   logic            done_q, done_d;
   logic            error_q, error_d;

   logic            clk_s, dat_s, clk_fall;

   assign clk_s    = clk_sync_q[1];
   assign dat_s    = dat_sync_q[1];
   assign clk_fall = clk_prev_q & ~clk_s;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         clk_sync_q  <= 2'b11;
         dat_sync_q  <= 2'b11;
         clk_prev_q  <= 1'b1;
         data_q      <= '0;
         parity_q    <= 1'b0;
         bit_cnt_q   <= '0;
         phase_cnt_q <= '0;
         tmo_q       <= '0;
         dat_oe_q    <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
         dat_sync_q  <= {dat_sync_q[0], ps2_dat_in};
         clk_prev_q  <= clk_sync_q[1];
         data_q      <= data_d;
         parity_q    <= parity_d;
         bit_cnt_q   <= bit_cnt_d;
         phase_cnt_q <= phase_cnt_d;
         tmo_q       <= tmo_d;
         dat_oe_q    <= dat_oe_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      parity_d    = parity_q;
      bit_cnt_d   = bit_cnt_q;
      phase_cnt_d = phase_cnt_q;
      tmo_d       = tmo_q;
      dat_oe_d    = dat_oe_q;
      done_d      = 1'b0;
      error_d     = 1'b0;

      case (state_q)
         IDLE: begin
            phase_cnt_d = '0;
            tmo_d       = '0;
            dat_oe_d    = 1'b0;
            if (send_valid) begin
               data_d    = send_data;
               parity_d  = ~^send_data;
               bit_cnt_d = '0;
               state_d   = INHIBIT;
            end
         end
         INHIBIT: begin
            if (phase_cnt_q == CW'(CLK_INHIBIT_CYCLES - 1)) begin
               phase_cnt_d = '0;
               state_d     = START;
            end else begin
               phase_cnt_d = phase_cnt_q + 1'b1;
            end
         end
         START: begin
            if (phase_cnt_q == CW'(START_HOLD_CYCLES - 1)) begin
               phase_cnt_d = '0;
               tmo_d       = '0;
               dat_oe_d    = 1'b1;
               state_d     = SEND;
            end else begin
               phase_cnt_d = phase_cnt_q + 1'b1;
            end
         end
         SEND, ACK, WAIT_IDLE: begin
            tmo_d = tmo_q + 1'b1;
            // The timeout wins over any line event landing in the same cycle.
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
               tmo_d    = '0;
               dat_oe_d = 1'b0;
               error_d  = 1'b1;
               state_d  = IDLE;
            end else if (state_q == SEND) begin
               if (clk_fall) begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q < 4'd8) begin
                     dat_oe_d = ~data_q[bit_cnt_q[2:0]];
                  end else if (bit_cnt_q == 4'd8) begin
                     dat_oe_d = ~parity_q;
                  end else begin
                     dat_oe_d = 1'b0;
                     state_d  = ACK;
                  end
               end
            end else if (state_q == ACK) begin
               if (clk_fall) begin
                  if (!dat_s) begin
                     state_d = WAIT_IDLE;
                  end else begin
                     error_d = 1'b1;
                     state_d = IDLE;
                  end
               end
            end else begin
               if (clk_s && dat_s) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ps2_clk_oe = (state_q == INHIBIT) || (state_q == START);
   assign ps2_dat_oe = (state_q == START) || ((state_q == SEND) && dat_oe_q);
   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed and random host-to-device transfers against an open-drain PS/2 device model.
module tb_ps2_host_tx;

   localparam int INH  = 10;
   localparam int SH   = 4;
   localparam int TMO  = 2000;
   localparam int HALF = 20;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] send_data = 8'h00;
   logic       send_valid = 1'b0;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   logic       ps2_clk_in, ps2_dat_in;
   logic       ps2_clk_oe, ps2_dat_oe, busy, done, error;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int both_cnt = 0;
   int wide_cnt = 0;
   bit done_prev = 1'b0;
   bit err_prev  = 1'b0;

   // Open-drain wired-AND of host and device drivers.
   assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

   ps2_host_tx #(
      .CLK_INHIBIT_CYCLES(INH),
      .START_HOLD_CYCLES (SH),
      .TIMEOUT_CYCLES    (TMO)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .send_data (send_data),
      .send_valid(send_valid),
      .ps2_clk_in(ps2_clk_in),
      .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (error === 1'b1) err_cnt <= err_cnt + 1;
      if (done === 1'b1 && error === 1'b1) both_cnt <= both_cnt + 1;
      if ((done === 1'b1 && done_prev) || (error === 1'b1 && err_prev)) wide_cnt <= wide_cnt + 1;
      done_prev <= (done === 1'b1);
      err_prev  <= (error === 1'b1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic chk_released(input string tag);
      chk({tag, "_busy"},   32'(busy), 32'd0);
      chk({tag, "_clk_oe"}, 32'(ps2_clk_oe), 32'd0);
      chk({tag, "_dat_oe"}, 32'(ps2_dat_oe), 32'd0);
   endtask

   // clocks=0: device stays silent; ack=0: device leaves data high at the ack clock.
   // inj_edge/rst_edge: falling edge at which a second request or a reset is applied (0 = none).
   task automatic run_xfer(input logic [7:0] b, input bit clocks, input bit ack,
                           input int inj_edge, input int rst_edge, output logic [9:0] rx);
      logic [9:0] exp_frame;
      int k, d0, e0, rel_cyc, t;
      bit aborted;
      d0        = done_cnt;
      e0        = err_cnt;
      rx        = '0;
      aborted   = 1'b0;
      exp_frame = {1'b1, ~^b, b};

      send_data  = b;
      send_valid = 1'b1;
      @(negedge clock);
      send_valid = 1'b0;
      send_data  = 8'($urandom);

      k = 0;
      while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && k < 4 * INH) begin
         k++;
         @(negedge clock);
      end
      chk("inhibit_len", 32'(k), 32'(INH));
      k = 0;
      while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b1 && k < 4 * INH) begin
         k++;
         @(negedge clock);
      end
      chk("start_hold_len", 32'(k), 32'(SH));
      chk("start_bit_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b01);
      rel_cyc = cyc;

      if (!clocks) begin
         t = 0;
         while (error !== 1'b1 && t < TMO + 500) begin
            t++;
            @(negedge clock);
         end
         chk("timeout_cycles", 32'(cyc - rel_cyc), 32'(TMO));
         chk_released("timeout");
         cycles(5);
         chk("timeout_err_cnt", 32'(err_cnt - e0), 32'd1);
         chk("timeout_done_cnt", 32'(done_cnt - d0), 32'd0);
      end else begin
         cycles(10);
         chk("start_bit_line", 32'(ps2_dat_in), 32'd0);
         for (int n = 1; n <= 11 && !aborted; n++) begin
            dev_clk_low = 1'b1;
            if (n == rst_edge) begin
               cycles(3);
               reset_n = 1'b0;
               @(negedge clock);
               reset_n = 1'b1;
               chk_released("reset");
               dev_clk_low = 1'b0;
               aborted     = 1'b1;
            end else begin
               if (n == inj_edge) begin
                  send_data  = 8'hAA;
                  send_valid = 1'b1;
                  @(negedge clock);
                  send_valid = 1'b0;
                  cycles(HALF - 1);
               end else begin
                  cycles(HALF);
               end
               dev_clk_low = 1'b0;
               if (n == 11) dev_dat_low = 1'b0;
               cycles(HALF / 2);
               if (n <= 10) rx[n-1] = ps2_dat_in;
               if (n == 10 && ack) dev_dat_low = 1'b1;
               cycles(HALF / 2);
            end
         end
         if (aborted) begin
            cycles(100);
            chk("reset_done_cnt", 32'(done_cnt - d0), 32'd0);
            chk("reset_err_cnt", 32'(err_cnt - e0), 32'd0);
            chk_released("reset_after");
         end else begin
            chk("frame", 32'(rx), 32'(exp_frame));
            chk("done_cnt", 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
            chk("err_cnt", 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
            chk_released("end");
         end
      end
   endtask

   initial begin
      logic [9:0] rx;
      logic [7:0] b;

      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [9:0] rx;
      logic [7:0] b;

      cycles(3);
      chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      chk("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
      chk("rst_busy",   32'(busy), 32'd0);
      chk("rst_done",   32'(done), 32'd0);
      chk("rst_error",  32'(error), 32'd0);
      reset_n = 1'b1;
      cycles(5);

      // 0xED with ack: LSB first 1,0,1,1,0,1,1,1 then parity 1, stop 1.
      run_xfer(8'hED, 1'b1, 1'b1, 0, 0, rx);
      chk("ed_bits", 32'(rx), 32'b11_1110_1101);
      cycles(10);

      // 0x07 without ack: parity bit must be 0.
      run_xfer(8'h07, 1'b1, 1'b0, 0, 0, rx);
      chk("07_parity", 32'(rx[8]), 32'd0);
      cycles(10);

      // 0x00 with a silent device.
      run_xfer(8'h00, 1'b0, 1'b0, 0, 0, rx);
      cycles(10);

      // 0x55 with a 0xAA request during data phase.
      run_xfer(8'h55, 1'b1, 1'b1, 3, 0, rx);
      chk("55_byte", 32'(rx[7:0]), 32'h55);
      cycles(60);
      chk("55_no_resend_busy", 32'(busy), 32'd0);
      chk("55_no_resend_clk", 32'(ps2_clk_oe), 32'd0);

      // 0xF0 reset at falling edge 5, then a clean retry.
      run_xfer(8'hF0, 1'b1, 1'b1, 0, 5, rx);
      cycles(10);
      run_xfer(8'hF0, 1'b1, 1'b1, 0, 0, rx);
      chk("f0_byte", 32'(rx[7:0]), 32'hF0);

      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom);
         cycles($urandom_range(1, 20));
         run_xfer(b, 1'b1, 1'b1, 0, 0, rx);
      end

      cycles(5);
      chk("done_error_overlap", 32'(both_cnt), 32'd0);
      chk("pulse_width", 32'(wide_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
